// File: rtl/ram_bist.sv
// ram_bist: march-test initiator for a single-port synchronous RAM.
// Runs: write A ascending; read A / write B ascending; read B / write A
// descending; read A ascending. Reports pass/fail plus the first failing
// address and the data read there.
//
// Optional feature macro: RAM_BIST_ERR_COUNT_EN
//   defined   -> err_cnt_o present, run never stops early, all mismatches counted
//   undefined -> run ends at the first mismatch, the write in that cycle is dropped
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          begin a run (sampled only in IDLE)
//   busy_o           high while the march is running
//   done_o           one-cycle pulse at end of run
//   pass_o           result of last run, held until the next accepted start
//   fail_adr_o       address of first mismatch
//   fail_data_o      data read at first mismatch
//   ram_w_o          RAM write enable       (combinational)
//   ram_adr_o        RAM address            (combinational)
//   ram_data_in_o    RAM write data         (combinational)
//   ram_data_out_i   RAM registered read data
//   err_cnt_o        mismatch count (RAM_BIST_ERR_COUNT_EN only)
module ram_bist #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADR_W  = 3,
    parameter int unsigned SIZE   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADR_W-1:0]  fail_adr_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic              ram_w_o,
    output logic [ADR_W-1:0]  ram_adr_o,
    output logic [DATA_W-1:0] ram_data_in_o,
    input  logic [DATA_W-1:0] ram_data_out_i
`ifdef RAM_BIST_ERR_COUNT_EN
    ,
    output logic [ADR_W+1:0]  err_cnt_o
`endif
);

    localparam int unsigned CNT_W = ADR_W + 2;
    localparam logic [ADR_W-1:0]  LAST_ADR = ADR_W'(SIZE - 1);
    localparam logic [DATA_W-1:0] PAT_A    = {(DATA_W/2){2'b01}};
    localparam logic [DATA_W-1:0] PAT_B    = ~PAT_A;

`ifdef RAM_BIST_ERR_COUNT_EN
    localparam bit STOP_ON_ERR = 1'b0;
`else
    localparam bit STOP_ON_ERR = 1'b1;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_WA,
        S_RA_RD,
        S_RA_WB,
        S_RB_RD,
        S_RB_WA,
        S_RF_RD,
        S_RF_CMP,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADR_W-1:0]  addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_seen_q, err_seen_d;
    logic [ADR_W-1:0]  fail_adr_q, fail_adr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              cmp_en_c;
    logic [DATA_W-1:0] exp_c;
    logic              mismatch_c;
    logic              ram_w_c;
    logic [DATA_W-1:0] ram_data_c;

    // Compare stage: read data arrives in the cycle after each *_RD state
    always_comb begin
        cmp_en_c = 1'b0;
        exp_c    = PAT_A;
        case (state_q)
            S_RA_WB:  cmp_en_c = 1'b1;
            S_RB_WA: begin
                cmp_en_c = 1'b1;
                exp_c    = PAT_B;
            end
            S_RF_CMP: cmp_en_c = 1'b1;
            default:  cmp_en_c = 1'b0;
        endcase
        mismatch_c = cmp_en_c && (ram_data_out_i != exp_c);
    end

    // Next-state, address sequencing and result capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        err_seen_d  = err_seen_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        err_cnt_d   = err_cnt_q;
        ram_w_c     = 1'b0;
        ram_data_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_WA;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    err_seen_d  = 1'b0;
                    fail_adr_d  = '0;
                    fail_data_d = '0;
                    err_cnt_d   = '0;
                end
            end
            S_WA: begin
                ram_w_c    = 1'b1;
                ram_data_c = PAT_A;
                if (addr_q == LAST_ADR) begin
                    state_d = S_RA_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADR_W'(1);
                end
            end
            S_RA_RD: state_d = S_RA_WB;
            S_RA_WB: begin
                ram_data_c = PAT_B;
                ram_w_c    = !(STOP_ON_ERR && mismatch_c);
                if (STOP_ON_ERR && mismatch_c) begin
                    state_d = S_DONE;
                end else if (addr_q == LAST_ADR) begin
                    state_d = S_RB_RD;
                    addr_d  = LAST_ADR;
                end else begin
                    state_d = S_RA_RD;
                    addr_d  = addr_q + ADR_W'(1);
                end
            end
            S_RB_RD: state_d = S_RB_WA;
            S_RB_WA: begin
                ram_data_c = PAT_A;
                ram_w_c    = !(STOP_ON_ERR && mismatch_c);
                if (STOP_ON_ERR && mismatch_c) begin
                    state_d = S_DONE;
                end else if (addr_q == '0) begin
                    state_d = S_RF_RD;
                    addr_d  = '0;
                end else begin
                    state_d = S_RB_RD;
                    addr_d  = addr_q - ADR_W'(1);
                end
            end
            S_RF_RD: state_d = S_RF_CMP;
            S_RF_CMP: begin
                if ((STOP_ON_ERR && mismatch_c) || (addr_q == LAST_ADR)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RF_RD;
                    addr_d  = addr_q + ADR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // First mismatch of the run is latched; later ones only count
        if (mismatch_c) begin
            if (!err_seen_q) begin
                err_seen_d  = 1'b1;
                fail_adr_d  = addr_q;
                fail_data_d = ram_data_out_i;
            end
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            pass_d = !(err_seen_q || mismatch_c);
        end
    end

    assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    assign done_d = (state_d == S_DONE);

    // State and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_seen_q  <= err_seen_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_adr_o    = fail_adr_q;
    assign fail_data_o   = fail_data_q;
    assign ram_w_o       = ram_w_c;
    assign ram_adr_o     = addr_q;
    assign ram_data_in_o = ram_data_c;

`ifdef RAM_BIST_ERR_COUNT_EN
    assign err_cnt_o = err_cnt_q;
`else
    // Counter only feeds the optional port
    logic unused_cnt;
    assign unused_cnt = ^err_cnt_q;
`endif

endmodule
